// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - 8b/10b shared tables, K constants and disparity type
package enc8b10b_pkg;

  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } disp_t;

  // fghj codes indexed by y (HGF); entry 7 is the primary D.x.7 code
  localparam logic [7:0][3:0] FGHJ_RDN = {
    4'b1110, 4'b0110, 4'b1010, 4'b1101, 4'b1100, 4'b0101, 4'b1001, 4'b1011
  };
  localparam logic [7:0][3:0] FGHJ_RDP = {
    4'b0001, 4'b0110, 4'b1010, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b0100
  };

  localparam logic [3:0] ALT7_RDN = 4'b0111;
  localparam logic [3:0] ALT7_RDP = 4'b1000;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam logic [4:0] K28_X      = 5'd28;
  localparam logic [7:0] K23_7      = 8'hF7;
  localparam logic [7:0] K27_7      = 8'hFB;
  localparam logic [7:0] K29_7      = 8'hFD;
  localparam logic [7:0] K30_7      = 8'hFE;
  localparam logic [5:0] K28_6B_RDN = 6'b001111;
  localparam logic [5:0] K28_6B_RDP = 6'b110000;

  function automatic logic is_valid_k(input logic [7:0] b);
    return (b[4:0] == K28_X) || (b == K23_7) || (b == K27_7) ||
           (b == K29_7) || (b == K30_7);
  endfunction

  // A7 avoids a run of five equal bits across the 6b/4b boundary
  function automatic logic alt7_needed(input logic [4:0] x, input logic rd6);
    if (!rd6)
      return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    else
      return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
  endfunction

endpackage

// File: rtl/enc3to4.sv
// rtl/enc3to4.sv - 3b/4b sub-block encoder (fghj) with A7 and K28 handling
module enc3to4
  import enc8b10b_pkg::*;
(
  input  logic [2:0] y,
  input  logic       rd6,
  input  logic       alt,
  input  logic       kflag,
  output logic [3:0] fghj
);

  always_comb begin
    fghj = rd6 ? FGHJ_RDP[y] : FGHJ_RDN[y];
    if ((y == 3'd7) && (alt || kflag)) begin
      fghj = rd6 ? ALT7_RDP : ALT7_RDN;
    end else if (kflag && !rd6 &&
                 ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) begin
      // K28.1/.2/.5/.6 after a 110000 6b code: complemented RD- data code
      fghj = ~FGHJ_RDN[y];
    end
  end

endmodule

// File: rtl/enc5to6.sv
// rtl/enc5to6.sv - 5b/6b sub-block encoder (abcdei), selected by running disparity
module enc5to6 (
  input  logic [4:0] datain,
  input  logic       rd,
  output logic [5:0] dataout
);

  logic [5:0] w_code_neg;
  logic       w_flip;

  always_comb begin
    w_code_neg = 6'b000000;
    case (datain)
      5'd0:  w_code_neg = 6'b100111;
      5'd1:  w_code_neg = 6'b011101;
      5'd2:  w_code_neg = 6'b101101;
      5'd3:  w_code_neg = 6'b110001;
      5'd4:  w_code_neg = 6'b110101;
      5'd5:  w_code_neg = 6'b101001;
      5'd6:  w_code_neg = 6'b011001;
      5'd7:  w_code_neg = 6'b111000;
      5'd8:  w_code_neg = 6'b111001;
      5'd9:  w_code_neg = 6'b100101;
      5'd10: w_code_neg = 6'b010101;
      5'd11: w_code_neg = 6'b110100;
      5'd12: w_code_neg = 6'b001101;
      5'd13: w_code_neg = 6'b101100;
      5'd14: w_code_neg = 6'b011100;
      5'd15: w_code_neg = 6'b010111;
      5'd16: w_code_neg = 6'b011011;
      5'd17: w_code_neg = 6'b100011;
      5'd18: w_code_neg = 6'b010011;
      5'd19: w_code_neg = 6'b110010;
      5'd20: w_code_neg = 6'b001011;
      5'd21: w_code_neg = 6'b101010;
      5'd22: w_code_neg = 6'b011010;
      5'd23: w_code_neg = 6'b111010;
      5'd24: w_code_neg = 6'b110011;
      5'd25: w_code_neg = 6'b100110;
      5'd26: w_code_neg = 6'b010110;
      5'd27: w_code_neg = 6'b110110;
      5'd28: w_code_neg = 6'b001110;
      5'd29: w_code_neg = 6'b101110;
      5'd30: w_code_neg = 6'b011110;
      5'd31: w_code_neg = 6'b101011;
      default: w_code_neg = 6'b000000;
    endcase
  end

  // RD+ form is the complement for unbalanced codes and for D.7 (111000/000111)
  assign w_flip  = rd && (($countones(w_code_neg) != 3) || (datain == 5'd7));
  assign dataout = w_flip ? ~w_code_neg : w_code_neg;

endmodule

// File: rtl/enc8b10b_pipe.sv
// rtl/enc8b10b_pipe.sv - registered 8b/10b encoder with valid/ready handshake; K chars under ENC8B10B_KCHAR_EN
module enc8b10b_pipe
  import enc8b10b_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
`ifdef ENC8B10B_KCHAR_EN
  input  logic       k_in,
  output logic       err_k,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] dout,
  output logic       rd_out
);

  logic [9:0] r_dout;
  logic       r_out_valid;
  disp_t      r_rd;

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_rd;
  logic [5:0] w_6b_data;
  logic [5:0] w_6b;
  logic       w_rd6;
  logic       w_alt;
  logic [3:0] w_4b;
  logic       w_rd_next;
  logic       w_kvalid;
  logic       w_accept;

  assign w_x  = din[4:0];
  assign w_y  = din[7:5];
  assign w_rd = r_rd;

  enc5to6 u_enc5to6 (
    .datain  (w_x),
    .rd      (w_rd),
    .dataout (w_6b_data)
  );

`ifdef ENC8B10B_KCHAR_EN
  logic w_kerr;
  logic w_k28;
  logic r_err_k;

  assign w_kvalid = k_in && is_valid_k(din);
  assign w_kerr   = k_in && !w_kvalid;
  assign w_k28    = w_kvalid && (w_x == K28_X);
  assign w_6b     = w_k28 ? (w_rd ? K28_6B_RDP : K28_6B_RDN) : w_6b_data;
  assign err_k    = r_err_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_k <= 1'b0;
    else if (w_accept)
      r_err_k <= w_kerr;
  end
`else
  assign w_kvalid = 1'b0;
  assign w_6b     = w_6b_data;
`endif

  assign w_rd6 = ($countones(w_6b) != 3) ? ~w_rd : w_rd;
  assign w_alt = alt7_needed(w_x, w_rd6);

  enc3to4 u_enc3to4 (
    .y     (w_y),
    .rd6   (w_rd6),
    .alt   (w_alt),
    .kflag (w_kvalid),
    .fghj  (w_4b)
  );

  assign w_rd_next = ($countones(w_4b) != 2) ? ~w_rd6 : w_rd6;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= 10'd0;
      r_out_valid <= 1'b0;
      r_rd        <= RD_NEG;
    end else if (w_accept) begin
      r_dout      <= {w_6b, w_4b};
      r_out_valid <= 1'b1;
      r_rd        <= disp_t'(w_rd_next);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign rd_out    = r_rd;

endmodule

// File: tb/tb_enc8b10b_pipe.sv
// tb/tb_enc8b10b_pipe.sv - directed and table-driven checks for enc8b10b_pipe
module tb_enc8b10b_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] din = 8'h00;
  logic       k_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] dout;
  logic       rd_out;
`ifdef ENC8B10B_KCHAR_EN
  logic       err_k;
`endif

  int n_total = 0;
  int n_pass  = 0;

  enc8b10b_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
`ifdef ENC8B10B_KCHAR_EN
    .k_in      (k_in),
    .err_k     (err_k),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] din;
    logic       k;
    logic [9:0] dout;
    logic       rd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Independent reference encoder; returns {rd_next, abcdei_fghj}
  function automatic logic [10:0] golden(input logic [7:0] d, input logic rd);
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unbal6, rd6, rdn;
    logic [4:0] x;
    logic [2:0] y;
    x = d[4:0];
    y = d[7:5];
    case (x)
      0: c6 = 6'b100111;  1: c6 = 6'b011101;  2: c6 = 6'b101101;  3: c6 = 6'b110001;
      4: c6 = 6'b110101;  5: c6 = 6'b101001;  6: c6 = 6'b011001;  7: c6 = 6'b111000;
      8: c6 = 6'b111001;  9: c6 = 6'b100101; 10: c6 = 6'b010101; 11: c6 = 6'b110100;
     12: c6 = 6'b001101; 13: c6 = 6'b101100; 14: c6 = 6'b011100; 15: c6 = 6'b010111;
     16: c6 = 6'b011011; 17: c6 = 6'b100011; 18: c6 = 6'b010011; 19: c6 = 6'b110010;
     20: c6 = 6'b001011; 21: c6 = 6'b101010; 22: c6 = 6'b011010; 23: c6 = 6'b111010;
     24: c6 = 6'b110011; 25: c6 = 6'b100110; 26: c6 = 6'b010110; 27: c6 = 6'b110110;
     28: c6 = 6'b001110; 29: c6 = 6'b101110; 30: c6 = 6'b011110; default: c6 = 6'b101011;
    endcase
    unbal6 = ($countones(c6) != 3);
    if (rd && (unbal6 || x == 5'd7)) c6 = ~c6;
    rd6 = rd ^ unbal6;
    if (!rd6) begin
      case (y)
        0: c4 = 4'b1011; 1: c4 = 4'b1001; 2: c4 = 4'b0101; 3: c4 = 4'b1100;
        4: c4 = 4'b1101; 5: c4 = 4'b1010; 6: c4 = 4'b0110; default: c4 = 4'b1110;
      endcase
      if (y == 3'd7 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) c4 = 4'b0111;
    end else begin
      case (y)
        0: c4 = 4'b0100; 1: c4 = 4'b1001; 2: c4 = 4'b0101; 3: c4 = 4'b0011;
        4: c4 = 4'b0010; 5: c4 = 4'b1010; 6: c4 = 4'b0110; default: c4 = 4'b0001;
      endcase
      if (y == 3'd7 && (x == 5'd11 || x == 5'd13 || x == 5'd14)) c4 = 4'b1000;
    end
    rdn = rd6 ^ ($countones(c4) != 2);
    return {rdn, c6, c4};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", {9'd0, out_valid}, 10'd0);
    check("reset_dout", dout, 10'd0);
    check("reset_rd", {9'd0, rd_out}, 10'd0);
`ifdef ENC8B10B_KCHAR_EN
    check("reset_err_k", {9'd0, err_k}, 10'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer a byte at the negedge; the accept edge follows. Leaves in_valid high.
  task automatic send(input logic [7:0] d, input logic k);
    @(negedge clk);
    in_valid = 1'b1;
    din = d;
    k_in = k;
    @(posedge clk);
    #1;
  endtask

  logic [10:0] g;
  logic        mrd;

  initial begin
    vecs[0] = '{8'h00, 1'b0, 10'b1001110100, 1'b0};
    vecs[1] = '{8'hF1, 1'b0, 10'b1000110111, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 10'b0110001011, 1'b1};
    vecs[3] = '{8'hF1, 1'b0, 10'b1000110001, 1'b0};
    vecs[4] = '{8'h0B, 1'b0, 10'b1101001011, 1'b1};
    vecs[5] = '{8'hEB, 1'b0, 10'b1101001000, 1'b0};
    vecs[6] = '{8'hE7, 1'b0, 10'b1110001110, 1'b1};
    vecs[7] = '{8'hE7, 1'b0, 10'b0001110001, 1'b0};
    vecs[8] = '{8'h6A, 1'b0, 10'b0101011100, 1'b0};
    vecs[9] = '{8'hFF, 1'b0, 10'b1010110001, 1'b0};

    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    do_reset();

    // Chained table: each vector encodes from the RD the previous one left
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].din, vecs[i].k);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
      check($sformatf("vec%0d_rd", i), {9'd0, rd_out}, {9'd0, vecs[i].rd});
      check($sformatf("vec%0d_valid", i), {9'd0, out_valid}, 10'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Backpressure: hold, then release with a same-edge accept
    do_reset();
    out_ready = 1'b0;
    send(8'h00, 1'b0);
    check("bp_first_dout", dout, 10'b1001110100);
    din = 8'hF1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", c), {9'd0, in_ready}, 10'd0);
      check($sformatf("bp_dout_hold_%0d", c), dout, 10'b1001110100);
      check($sformatf("bp_rd_hold_%0d", c), {9'd0, rd_out}, 10'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp_release_ready", {9'd0, in_ready}, 10'd1);
    @(posedge clk);
    #1;
    check("bp_next_dout", dout, 10'b1000110111);
    check("bp_next_rd", {9'd0, rd_out}, 10'd1);
    check("bp_next_valid", {9'd0, out_valid}, 10'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", {9'd0, out_valid}, 10'd0);
    check("drain_rd_hold", {9'd0, rd_out}, 10'd1);

    // Reset with a pending symbol and RD+
    do_reset();
    out_ready = 1'b0;
    send(8'hF1, 1'b0);
    check("pre_rst_rd", {9'd0, rd_out}, 10'd1);
    check("pre_rst_valid", {9'd0, out_valid}, 10'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {9'd0, out_valid}, 10'd0);
    check("rst_async_rd", {9'd0, rd_out}, 10'd0);
    check("rst_async_dout", dout, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h00, 1'b0);
    check("post_rst_dout", dout, 10'b1001110100);
    check("post_rst_rd", {9'd0, rd_out}, 10'd0);
    @(negedge clk);
    in_valid = 1'b0;

`ifdef ENC8B10B_KCHAR_EN
    do_reset();
    send(8'hBC, 1'b1);
    check("k28_5_a_dout", dout, 10'b0011111010);
    check("k28_5_a_rd", {9'd0, rd_out}, 10'd1);
    check("k28_5_a_err", {9'd0, err_k}, 10'd0);
    send(8'hBC, 1'b1);
    check("k28_5_b_dout", dout, 10'b1100000101);
    check("k28_5_b_rd", {9'd0, rd_out}, 10'd0);
    send(8'h00, 1'b1);
    check("kerr_dout", dout, 10'b1001110100);
    check("kerr_flag", {9'd0, err_k}, 10'd1);
    send(8'hF7, 1'b1);
    check("k23_7_dout", dout, 10'b1110101000);
    check("k23_7_err", {9'd0, err_k}, 10'd0);
    @(negedge clk);
    in_valid = 1'b0;
    k_in = 1'b0;
`else
    // Full data sweep against the reference model
    do_reset();
    mrd = 1'b0;
    for (int b = 0; b < 256; b++) begin
      g = golden(8'(b), mrd);
      send(8'(b), 1'b0);
      check($sformatf("sweep_%02h_dout", b), dout, g[9:0]);
      check($sformatf("sweep_%02h_rd", b), {9'd0, rd_out}, {9'd0, g[10]});
      mrd = g[10];
    end
    @(negedge clk);
    in_valid = 1'b0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
